// File: rtl/bpu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bpu                                                           |
// | Brief    : Fetch-block next-PC generator (gshare PHT, tagged BTB, RAS)   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module bpu #(
    parameter logic [63:0] RST_PC = 64'h8000_0000,
    parameter int          CBSZ   = 64,
    parameter int          FNUM   = 4,
    parameter int          PHTSZ  = 256,
    parameter int          BTBSZ  = 64,
    parameter int          HISTW  = 8,
    parameter int          RASSZ  = 8,
    localparam int         RSPW   = $clog2(RASSZ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redir,
    input  logic             reinf,
    input  logic [63:0]      upc,
    input  logic [63:0]      unpc,
    input  logic [2:0]       ukind,
    input  logic             ulen,
    input  logic             utaken,
    input  logic [HISTW-1:0] uhist,
    input  logic [RSPW-1:0]  ursp,
    input  logic             ready,
    output logic             out_valid,
    output logic [7:0]       out_id,
    output logic [63:0]      out_pc,
    output logic [7:0]       out_num,
    output logic             out_br,
    output logic [63:0]      out_tgt,
    output logic [HISTW-1:0] out_hist,
    output logic [RSPW-1:0]  out_rsp
);
    localparam int PHTW = $clog2(PHTSZ);
    localparam int BTBW = $clog2(BTBSZ);
    localparam int CBW  = $clog2(CBSZ);
    localparam int CNTW = $clog2(RASSZ + 1);

    localparam logic [2:0] K_NONE = 3'd0;
    localparam logic [2:0] K_COND = 3'd1;
    localparam logic [2:0] K_CALL = 3'd3;
    localparam logic [2:0] K_RET  = 3'd4;

    typedef struct packed {
        logic        valid;
        logic [15:0] tag;
        logic [63:0] tgt;
        logic [2:0]  kind;
        logic        len;
    } btb_ent_t;

    logic             valid_q, valid_d;
    logic [63:0]      pc_q, pc_d;
    logic [6:0]       id_q, id_d;
    logic [HISTW-1:0] ghr_q, ghr_d;
    logic [RSPW-1:0]  rsp_q, rsp_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [63:0]      ras_q [RASSZ];
    logic [63:0]      ras_d [RASSZ];
    logic [1:0]       pht_q [PHTSZ];
    logic [1:0]       pht_d [PHTSZ];
    btb_ent_t         btb_q [BTBSZ];
    btb_ent_t         btb_d [BTBSZ];

    logic [FNUM-1:0]  slot_cond;
    logic             tk_found;
    logic [7:0]       tk_slot;
    logic [63:0]      tk_spc;
    btb_ent_t         tk_ent;
    logic [CBW:0]     room_bytes;
    logic [7:0]       room;
    logic [7:0]       num_raw;
    logic             accept;

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? c : c + 2'd1;
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Scan slots in order; the first predicted-taken one ends the block.
    always_comb begin
        logic [63:0]     spc;
        btb_ent_t        ent;
        logic [PHTW-1:0] pidx;
        logic            hit;
        spc       = pc_q;
        ent       = '0;
        pidx      = '0;
        hit       = 1'b0;
        slot_cond = '0;
        tk_found  = 1'b0;
        tk_slot   = '0;
        tk_spc    = pc_q;
        tk_ent    = '0;
        for (int i = 0; i < FNUM; i++) begin
            spc  = pc_q + 64'(2 * i);
            ent  = btb_q[spc[BTBW:1]];
            pidx = spc[PHTW:1] ^ PHTW'(ghr_q);
            hit  = ent.valid && (ent.tag == spc[BTBW+16:BTBW+1]);
            slot_cond[i] = hit && (ent.kind == K_COND);
            if (!tk_found && hit && ((ent.kind != K_COND) || pht_q[pidx][1])) begin
                tk_found = 1'b1;
                tk_slot  = 8'(i);
                tk_spc   = spc;
                tk_ent   = ent;
            end
        end
    end

    always_comb begin
        room_bytes = (CBW+1)'(CBSZ) - {1'b0, pc_q[CBW-1:0]};
        room       = 8'(room_bytes >> 1);
        num_raw    = tk_found ? tk_slot + 8'd1 : 8'(FNUM);
        out_num    = num_raw;
        out_br     = tk_found;
        if (tk_found && (tk_ent.kind == K_RET) && (cnt_q != '0))
            out_tgt = ras_q[rsp_q - RSPW'(1)];
        else
            out_tgt = tk_ent.tgt;
        // A taken slot past the cache-block end never belongs to this block.
        if (num_raw > room) begin
            out_num = room;
            out_br  = 1'b0;
        end
        if (!out_br)
            out_tgt = pc_q + {55'd0, out_num, 1'b0};
    end

    assign accept = valid_q && ready && !redir;

    always_comb begin
        logic [BTBW-1:0] uidx;
        logic [15:0]     utag;
        logic [PHTW-1:0] upidx;
        logic            cond_seen;
        valid_d = 1'b1;
        pc_d    = pc_q;
        id_d    = id_q;
        ghr_d   = ghr_q;
        rsp_d   = rsp_q;
        cnt_d   = cnt_q;
        ras_d   = ras_q;
        pht_d   = pht_q;
        btb_d   = btb_q;
        uidx    = upc[BTBW:1];
        utag    = upc[BTBW+16:BTBW+1];
        upidx   = upc[PHTW:1] ^ PHTW'(uhist);
        cond_seen = 1'b0;
        for (int i = 0; i < FNUM; i++)
            if (slot_cond[i] && (8'(i) < out_num)) cond_seen = 1'b1;

        if (redir) begin
            pc_d  = unpc;
            id_d  = '0;
            ghr_d = (ukind == K_COND) ? {uhist[HISTW-2:0], utaken} : uhist;
            rsp_d = ursp;
            if (ukind == K_CALL) begin
                ras_d[ursp] = upc + (ulen ? 64'd4 : 64'd2);
                rsp_d       = ursp + RSPW'(1);
                if (cnt_q != CNTW'(RASSZ)) cnt_d = cnt_q + CNTW'(1);
            end else if ((ukind == K_RET) && (cnt_q != '0)) begin
                rsp_d = ursp - RSPW'(1);
                cnt_d = cnt_q - CNTW'(1);
            end
            if (ukind == K_COND)
                pht_d[upidx] = sat2(pht_q[upidx], utaken);
            if (ukind == K_NONE) begin
                if (btb_q[uidx].valid && (btb_q[uidx].tag == utag))
                    btb_d[uidx].valid = 1'b0;
            end else if (utaken) begin
                btb_d[uidx].valid = 1'b1;
                btb_d[uidx].tag   = utag;
                btb_d[uidx].tgt   = unpc;
                btb_d[uidx].kind  = ukind;
                btb_d[uidx].len   = ulen;
            end
        end else begin
            if (reinf && (ukind == K_COND))
                pht_d[upidx] = sat2(pht_q[upidx], utaken);
            if (accept) begin
                pc_d = out_tgt;
                id_d = id_q + 7'd1;
                if (cond_seen)
                    ghr_d = {ghr_q[HISTW-2:0], out_br && (tk_ent.kind == K_COND)};
                if (out_br && (tk_ent.kind == K_CALL)) begin
                    ras_d[rsp_q] = tk_spc + (tk_ent.len ? 64'd4 : 64'd2);
                    rsp_d        = rsp_q + RSPW'(1);
                    if (cnt_q != CNTW'(RASSZ)) cnt_d = cnt_q + CNTW'(1);
                end else if (out_br && (tk_ent.kind == K_RET) && (cnt_q != '0)) begin
                    rsp_d = rsp_q - RSPW'(1);
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= RST_PC;
            id_q    <= '0;
            ghr_q   <= '0;
            rsp_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < RASSZ; i++) ras_q[i] <= '0;
            for (int i = 0; i < PHTSZ; i++) pht_q[i] <= 2'b01;
            for (int i = 0; i < BTBSZ; i++) btb_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            id_q    <= id_d;
            ghr_q   <= ghr_d;
            rsp_q   <= rsp_d;
            cnt_q   <= cnt_d;
            ras_q   <= ras_d;
            pht_q   <= pht_d;
            btb_q   <= btb_d;
        end
    end

    assign out_valid = valid_q;
    assign out_id    = {1'b1, id_q};
    assign out_pc    = pc_q;
    assign out_hist  = ghr_q;
    assign out_rsp   = rsp_q;

endmodule
`default_nettype wire

// File: tb/tb_bpu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bpu                                                        |
// | Brief    : Directed + random bench for bpu against a table-level model   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_bpu;
    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [2:0] K_NONE = 3'd0, K_COND = 3'd1, K_JUMP = 3'd2,
                           K_CALL = 3'd3, K_RET = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redir = 1'b0, reinf = 1'b0, ulen = 1'b0, utaken = 1'b0, ready = 1'b0;
    logic [63:0] upc = '0, unpc = '0;
    logic [2:0]  ukind = '0;
    logic [7:0]  uhist = '0;
    logic [2:0]  ursp = '0;
    logic        out_valid, out_br;
    logic [7:0]  out_id, out_num, out_hist;
    logic [63:0] out_pc, out_tgt;
    logic [2:0]  out_rsp;

    bpu dut (
        .clk(clk), .rst(rst), .redir(redir), .reinf(reinf), .upc(upc), .unpc(unpc),
        .ukind(ukind), .ulen(ulen), .utaken(utaken), .uhist(uhist), .ursp(ursp),
        .ready(ready), .out_valid(out_valid), .out_id(out_id), .out_pc(out_pc),
        .out_num(out_num), .out_br(out_br), .out_tgt(out_tgt), .out_hist(out_hist),
        .out_rsp(out_rsp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state kept as plain arrays and integers.
    bit          m_valid;
    logic [63:0] m_pc;
    int          m_id, m_rsp, m_cnt;
    logic [7:0]  m_ghr;
    logic [63:0] m_ras [8];
    int          m_pht [256];
    bit          bv [64];
    logic [15:0] btag [64];
    logic [63:0] btgt [64];
    logic [2:0]  bkind [64];
    bit          blen [64];

    int          p_num;
    bit          p_br, p_len, p_condhit;
    logic [63:0] p_tgt, p_end;
    logic [2:0]  p_kind;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_valid = 0; m_pc = RST_PC; m_id = 0; m_ghr = '0; m_rsp = 0; m_cnt = 0;
        for (int i = 0; i < 8; i++) m_ras[i] = '0;
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        for (int i = 0; i < 64; i++) bv[i] = 0;
    endfunction

    function automatic void predict();
        int          room, b;
        logic [63:0] a;
        bit          hit;
        p_num = 4; p_br = 0; p_kind = K_NONE; p_end = m_pc; p_len = 0; p_condhit = 0;
        p_tgt = '0;
        room = (64 - int'(m_pc[5:0])) / 2;
        for (int i = 0; i < 4; i++) begin
            if (i >= room) break;
            a   = m_pc + 64'(2 * i);
            b   = int'(a[6:1]);
            hit = bv[b] && (btag[b] == a[22:7]);
            if (hit && bkind[b] == K_COND) p_condhit = 1;
            if (hit && (bkind[b] != K_COND || m_pht[int'(a[8:1] ^ m_ghr)] >= 2)) begin
                p_num = i + 1; p_br = 1; p_kind = bkind[b]; p_end = a; p_len = blen[b];
                p_tgt = (bkind[b] == K_RET && m_cnt > 0) ? m_ras[(m_rsp + 7) % 8] : btgt[b];
                break;
            end
        end
        if (p_num > room) p_num = room;
        if (!p_br) p_tgt = m_pc + 64'(2 * p_num);
    endfunction

    function automatic void push(input logic [63:0] ra);
        m_ras[m_rsp] = ra;
        m_rsp = (m_rsp + 1) % 8;
        if (m_cnt < 8) m_cnt++;
    endfunction

    function automatic void pop();
        if (m_cnt > 0) begin
            m_rsp = (m_rsp + 7) % 8;
            m_cnt--;
        end
    endfunction

    function automatic void pht_step(input int i, input bit t);
        if (t) m_pht[i] = (m_pht[i] < 3) ? m_pht[i] + 1 : 3;
        else   m_pht[i] = (m_pht[i] > 0) ? m_pht[i] - 1 : 0;
    endfunction

    function automatic void model_edge();
        int b;
        predict();
        if (redir) begin
            m_pc = unpc; m_id = 0;
            m_ghr = (ukind == K_COND) ? {uhist[6:0], utaken} : uhist;
            m_rsp = int'(ursp);
            if (ukind == K_CALL) push(upc + (ulen ? 64'd4 : 64'd2));
            else if (ukind == K_RET) pop();
            if (ukind == K_COND) pht_step(int'(upc[8:1] ^ uhist), utaken);
            b = int'(upc[6:1]);
            if (ukind == K_NONE) begin
                if (bv[b] && btag[b] == upc[22:7]) bv[b] = 0;
            end else if (utaken) begin
                bv[b] = 1; btag[b] = upc[22:7]; btgt[b] = unpc; bkind[b] = ukind; blen[b] = ulen;
            end
        end else begin
            if (reinf && ukind == K_COND) pht_step(int'(upc[8:1] ^ uhist), utaken);
            if (m_valid && ready) begin
                m_pc = p_tgt;
                m_id = (m_id + 1) % 128;
                if (p_condhit) m_ghr = {m_ghr[6:0], p_br && p_kind == K_COND};
                if (p_br && p_kind == K_CALL) push(p_end + (p_len ? 64'd4 : 64'd2));
                else if (p_br && p_kind == K_RET) pop();
            end
        end
        m_valid = 1;
    endfunction

    task automatic check_outputs();
        predict();
        chk("valid", 64'(out_valid), 64'(m_valid));
        chk("pc",    out_pc, m_pc);
        chk("id",    64'(out_id), 64'(8'h80 | 8'(m_id)));
        chk("num",   64'(out_num), 64'(p_num));
        chk("br",    64'(out_br), 64'(p_br));
        chk("tgt",   out_tgt, p_tgt);
        chk("hist",  64'(out_hist), 64'(m_ghr));
        chk("rsp",   64'(out_rsp), 64'(m_rsp));
    endtask

    // Called at a falling edge: drive, check, clock, update model.
    task automatic cycle(input bit rd, input bit rf, input bit rdy,
                         input logic [63:0] a_upc, input logic [63:0] a_unpc,
                         input logic [2:0] k, input bit ln, input bit tk,
                         input logic [7:0] h, input logic [2:0] sp);
        redir = rd; reinf = rf; ready = rdy; upc = a_upc; unpc = a_unpc;
        ukind = k; ulen = ln; utaken = tk; uhist = h; ursp = sp;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        cycle(0, 0, rdy, '0, '0, K_NONE, 0, 0, '0, '0);
    endtask

    task automatic go(input logic [63:0] pc);
        cycle(1, 0, 0, '0, pc, K_NONE, 0, 0, '0, '0);
    endtask

    function automatic logic [63:0] aa(input int j);
        return 64'h8000_2000 + 64'(136 * j);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r;
        logic [2:0]  k;
        bit          tk;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_outputs();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_id", 64'(out_id), 64'h80);
        chk("rst_pc", out_pc, RST_PC);
        rst = 1'b0;

        // Sequential blocks and block-boundary clamp
        idle(1);
        chk("tp_pc0", out_pc, 64'h8000_0000);
        chk("tp_id0", 64'(out_id), 64'h80);
        chk("tp_num0", 64'(out_num), 64'd4);
        idle(1);
        chk("tp_pc1", out_pc, 64'h8000_0008);
        chk("tp_id1", 64'(out_id), 64'h81);
        idle(1);
        chk("tp_pc2", out_pc, 64'h8000_0010);
        chk("tp_id2", 64'(out_id), 64'h82);
        go(64'h8000_003C);
        chk("clamp_num", 64'(out_num), 64'd2);
        chk("clamp_br", 64'(out_br), 64'd0);
        idle(1);
        chk("clamp_next", out_pc, 64'h8000_0040);

        // Jump training
        cycle(1, 0, 1, 64'h8000_0104, 64'h8000_0200, K_JUMP, 1, 1, '0, '0);
        chk("jmp_pc", out_pc, 64'h8000_0200);
        chk("jmp_id", 64'(out_id), 64'h80);
        go(64'h8000_0100);
        chk("jmp_num", 64'(out_num), 64'd3);
        chk("jmp_br", 64'(out_br), 64'd1);
        chk("jmp_tgt", out_tgt, 64'h8000_0200);

        // Conditional branch counter walk
        cycle(1, 0, 0, 64'h8000_0104, 64'h8000_0300, K_COND, 1, 1, '0, '0);
        go(64'h8000_0100);
        chk("cond_tk_num", 64'(out_num), 64'd3);
        chk("cond_tk_tgt", out_tgt, 64'h8000_0300);
        cycle(0, 1, 0, 64'h8000_0104, '0, K_COND, 1, 0, '0, '0);
        cycle(0, 1, 0, 64'h8000_0104, '0, K_COND, 1, 0, '0, '0);
        chk("cond_nt_num", 64'(out_num), 64'd4);
        chk("cond_nt_br", 64'(out_br), 64'd0);
        idle(1);

        // Call / return
        cycle(1, 0, 0, 64'h8000_0010, 64'h8000_1000, K_CALL, 1, 1, '0, 3'd0);
        cycle(1, 0, 0, 64'h8000_1000, 64'h8000_0014, K_RET, 0, 1, '0, 3'd1);
        go(64'h8000_0010);
        chk("call_tgt", out_tgt, 64'h8000_1000);
        idle(1);
        chk("ret_tgt", out_tgt, 64'h8000_0014);

        // Nine nested calls overflow the eight-entry RAS
        for (int j = 0; j < 9; j++)
            cycle(1, 0, 0, aa(j), aa(j + 1), K_CALL, 1, 1, '0, '0);
        for (int j = 0; j <= 9; j++)
            cycle(1, 0, 0, (j == 9) ? aa(9) : aa(j) + 64'd4, 64'h8000_0800, K_RET, 0, 1, '0, '0);
        go(aa(0));
        for (int j = 0; j < 9; j++) idle(1);
        for (int p = 1; p <= 9; p++) begin
            if (p == 8) chk("ras_pop8", out_tgt, aa(1) + 64'd4);
            if (p == 9) chk("ras_empty", out_tgt, 64'h8000_0800);
            idle(1);
        end

        // Redirect, reinforcement and ready together
        repeat (3) idle(1);
        cycle(1, 1, 1, 64'h8000_0104, 64'h8000_0600, K_COND, 1, 1, '0, '0);
        chk("coll_pc", out_pc, 64'h8000_0600);
        chk("coll_id", 64'(out_id), 64'h80);

        // Random traffic in a small address window
        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 99));
            k  = 3'($urandom_range(0, 4));
            tk = (k == K_COND) ? bit'($urandom_range(0, 1)) : (k != K_NONE);
            cycle(r < 20, (r >= 20) && (r < 35), $urandom_range(0, 3) != 0,
                  64'h8000_0000 + 64'(2 * $urandom_range(0, 127)),
                  64'h8000_0000 + 64'(2 * $urandom_range(0, 127)),
                  k, bit'($urandom_range(0, 1)), tk,
                  8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        end

        // Asynchronous reset pulse between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_pc", out_pc, RST_PC);
        chk("arst_id", 64'(out_id), 64'h80);
        chk("arst_hist", 64'(out_hist), 64'd0);
        chk("arst_rsp", 64'(out_rsp), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bpu.md
# bpu

Next-generation PC generator and branch predictor for the frontend. Every cycle it offers one fetch block (start PC, slot count, predicted target) to the fetch target queue. Prediction uses gshare (PHT indexed by PC xor global history), a tagged BTB with branch kinds, and a speculative return address stack (RAS). Mispredict redirects and commit reinforcements arrive from the backend; both carry the history and RAS snapshots issued with the block.

## Interface
- rst_pc, 64'h80000000, reset fetch PC
- cbsz, 64, cache block size in bytes; fetch blocks never cross it
- fnum, 4, max 2-byte slots per fetch block
- phtsz, 256, PHT entries (power of 2)
- btbsz, 64, BTB entries (power of 2)
- histw, 8, global history bits (≤ log2(phtsz))
- rassz, 8, RAS entries (power of 2)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redir  in  1  mispredict redirect
- reinf  in  1  commit-time reinforcement of a correct prediction
- upc  in  64  PC of the updating branch slot
- unpc  in  64  correct next PC
- ukind  in  3  0 none, 1 cond, 2 jump, 3 call, 4 ret
- ulen  in  1  1 = 4-byte instruction, 0 = 2-byte
- utaken  in  1  resolved direction
- uhist  in  histw  history snapshot issued with the block
- ursp  in  log2(rassz)  RAS pointer snapshot issued with the block
- ready  in  1  FTQ accepts the current block
- out_valid  out  1  block valid
- out_id  out  8  {1'b1, 7-bit sequence number}
- out_pc  out  64  block start PC
- out_num  out  8  slots in block, 1..fnum
- out_br  out  1  block ends in a predicted-taken branch
- out_tgt  out  64  predicted next PC
- out_hist  out  histw  history before this block
- out_rsp  out  log2(rassz)  RAS pointer before this block

## Operation
- State: pc_r, id_r[6:0], ghr[histw-1:0], RAS array plus rsp. Flop-array PHT (2-bit counters) and BTB (valid, 16-bit tag, target, kind, len).
- Slot i (0..fnum-1) has PC spc = pc_r + 2i.
  - PHT index: spc[log2(phtsz):1] xor zero-extended ghr.
  - BTB index: spc[log2(btbsz):1]. Tag: spc[log2(btbsz)+16:log2(btbsz)+1].
- Slot is taken iff BTB valid, tag matches, and (kind ≠ cond or PHT[1] = 1). The first taken slot k ends the block: out_num = k+1, out_br = 1.
  - Target for ret with RAS non-empty: RAS[rsp-1]. Otherwise: BTB target.
  - No taken slot: out_num = fnum, out_br = 0, out_tgt = pc_r + 2*out_num.
- Block-boundary clamp: let r = (cbsz - pc_r mod cbsz)/2. If out_num > r, then out_num = r, out_br = 0, out_tgt = pc_r + 2r.
- Accept (out_valid & ready & !redir):
  - pc_r ← out_tgt; id_r ← id_r+1 (wraps at 128).
  - If any BTB-hit cond slot lies within out_num: ghr ← {ghr[histw-2:0], taken-on-cond}, where taken-on-cond = out_br & slot kind = cond.
  - Taken call: RAS[rsp] ← spc + (len ? 4 : 2), rsp+1.
  - Taken ret: rsp−1.
- RAS is circular. Overflow overwrites the oldest entry. Empty is tracked by a saturating count; pop when empty leaves rsp unchanged.
- redir (wins over reinf and accept):
  - pc_r ← unpc; id_r ← 0.
  - ghr ← cond ? {uhist[histw-2:0], utaken} : uhist.
  - rsp ← ursp, then the call push (upc+len) or ret pop is applied.
  - PHT at (upc, uhist) moves one step toward utaken, saturating; only when ukind = cond.
  - If utaken: BTB entry written valid with tag, unpc, ukind, ulen.
  - If ukind = none: BTB entry at upc invalidated when its tag matches.
- reinf without redir: PHT saturating update only; no pointer or PC change.

## Timing
- Prediction is combinational from registered state. All updates are visible the next cycle.
- A redirect in cycle t presents out_pc = unpc, out_id = 0x80 in cycle t+1.
- A table write in cycle t does not affect the cycle-t prediction; reads return old data.
- While rst is high: out_valid = 0, pc_r = rst_pc, id_r = 0, ghr = 0, rsp = 0, RAS count = 0, all BTB valid = 0, all PHT = 2'b01.
- out_valid = 1 from the first cycle after rst deasserts.
- rst asserted mid-operation clears state immediately, with no clock edge needed.

## Test plan
- Reset, ready=1, empty tables → out_pc 0x80000000, 0x80000008, 0x80000010; out_num 4; out_id 0x80, 0x81, 0x82. Redirect to 0x8000003C → out_num 2, then out_pc 0x80000040.
- redir upc=0x80000104, unpc=0x80000200, ukind=jump, utaken=1 → next out_pc 0x80000200, out_id 0x80. Then redirect to 0x80000100 → out_num 3, out_br 1, out_tgt 0x80000200.
- Cond at 0x80000104, ghr=0: one redir with utaken=1 moves PHT 01→10 and predicts taken. Two reinf with utaken=0 drive it to 00 and predict fall-through (out_num 4).
- Train call 0x80000010 (len 1) → 0x80001000, and ret at 0x80001000. Fetch 0x80000010 → out_tgt 0x80001000; next block → out_tgt 0x80000014. Nine nested calls → oldest entry overwritten, eighth pop correct.
- redir, reinf and ready in the same cycle → only the redirect takes effect and id restarts at 0x80. Async rst pulse mid-stream → outputs return to reset values before the next clock edge.
